// File: rtl/lsq_data_mem_resp.sv
// Memory-side responder for the LSQ arbiter: word-addressed data array,
// fixed-latency load pipeline and a credit-limited response FIFO.
module lsq_data_mem_resp #(
  parameter int AW_MEM = 6,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flsh,
  input  logic        st_req,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  output logic        st_ack,
  input  logic        ld_req,
  input  logic [15:0] ld_addr,
  input  logic [5:0]  ld_idx,
  input  logic [5:0]  ld_phy,
  output logic        ld_ack,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_data,
  output logic [5:0]  rsp_idx,
  output logic [5:0]  rsp_phy,
  output logic        busy
);

  localparam int EW    = 28;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW    = $clog2(QDEPTH + LAT) + 1;
  localparam int DEPTH = 1 << AW_MEM;

  logic [15:0]   mem [DEPTH];
  logic [EW-1:0] ld_ent;
  logic          push_vld;
  logic [EW-1:0] push_ent;
  logic [OW-1:0] stg_cnt;
  logic [OW-1:0] cnt;
  logic [OW-1:0] occ;
  logic [EW-1:0] fifo [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  // Address bits above AW_MEM alias onto the same word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{ld_addr[15:AW_MEM], st_addr[15:AW_MEM]};

  // Stores always win arbitration; loads need a free credit and no flush.
  assign occ    = stg_cnt + cnt;
  assign busy   = (occ == OW'(QDEPTH));
  assign st_ack = st_req & rst;
  assign ld_ack = rst & ld_req & ~st_req & ~flsh & (occ < OW'(QDEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_req) begin
      mem[st_addr[AW_MEM-1:0]] <= st_data;
    end
  end

  assign ld_ent = {mem[ld_addr[AW_MEM-1:0]], ld_idx, ld_phy};

  generate
    if (LAT == 1) begin : g_nopipe
      assign push_vld = ld_ack;
      assign push_ent = ld_ent;
      assign stg_cnt  = '0;
    end else begin : g_pipe
      localparam int NS = LAT - 1;
      logic [NS-1:0] vld;
      logic [EW-1:0] ent [NS];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
          for (int i = 0; i < NS; i++) ent[i] <= '0;
        end else begin
          if (flsh) begin
            vld <= '0;
          end else begin
            vld[0] <= ld_ack;
            for (int i = 1; i < NS; i++) vld[i] <= vld[i-1];
          end
          ent[0] <= ld_ent;
          for (int i = 1; i < NS; i++) ent[i] <= ent[i-1];
        end
      end

      always_comb begin
        stg_cnt = '0;
        for (int i = 0; i < NS; i++) stg_cnt = stg_cnt + OW'(vld[i]);
      end

      assign push_vld = vld[NS-1];
      assign push_ent = ent[NS-1];
    end
  endgenerate

  // Response handshake: rsp_* shows the FIFO head while rsp_vld is high and
  // holds steady until the edge where rsp_vld & rsp_rdy, which pops it.
  assign rsp_vld = (cnt != '0);
  assign pop     = rsp_vld & rsp_rdy;
  assign {rsp_data, rsp_idx, rsp_phy} = fifo[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush beats both a coincident push from the pipeline and a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < QDEPTH; i++) fifo[i] <= '0;
    end else if (flsh) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) begin
        fifo[wr_ptr] <= push_ent;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + OW'(push_vld) - OW'(pop);
    end
  end

endmodule
